// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the ALU control unit and the sequential multiplier.
// The master issues operands with start; the slave answers with ready/busy/valid/result.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   inp1;
  logic [WIDTH-1:0]   inp2;
  logic               ready;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_mode, inp1, inp2,
    input  ready, busy, valid, result
  );

  modport slave (
    input  start, signed_mode, inp1, inp2,
    output ready, busy, valid, result
  );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: WIDTH/BITS_PER_CYCLE iterations on operand magnitudes,
// sign applied once on the final iteration. Fixed, data-independent latency.
module seq_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  seq_multiplier_if.slave bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               neg_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic [WIDTH-1:0]   mag1, mag2;
  logic               last_iter;
  logic [2*WIDTH-1:0] pp_sum;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] pp_term [BITS_PER_CYCLE];

  // Negating -2^(WIDTH-1) yields the same bit pattern, which is its correct unsigned magnitude.
  assign mag1 = (bus.signed_mode && bus.inp1[WIDTH-1]) ? -bus.inp1 : bus.inp1;
  assign mag2 = (bus.signed_mode && bus.inp2[WIDTH-1]) ? -bus.inp2 : bus.inp2;
  assign last_iter = (cnt_reg == LAST);

  // One shifted copy of the multiplicand per multiplier bit retired this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp_term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
    acc_sum = acc_reg + pp_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (bus.start) state_next = BUSY;
      BUSY:       if (last_iter) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mag1};
            mplier_reg <= mag2;
            neg_reg    <= bus.signed_mode & (bus.inp1[WIDTH-1] ^ bus.inp2[WIDTH-1]);
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        BUSY: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
          mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
          cnt_reg    <= cnt_reg + CW'(1);
          if (last_iter) result_reg <= neg_reg ? -acc_sum : acc_sum;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ready  = (state_reg == IDLE) || (state_reg == DONE);
    bus.busy   = (state_reg == BUSY);
    bus.valid  = (state_reg == DONE);
    bus.result = result_reg;
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier in three configurations
// (32x1, 32x4, 8x2) against an arithmetic product model.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(32)) bus_a ();
  seq_multiplier_if #(.WIDTH(32)) bus_b ();
  seq_multiplier_if #(.WIDTH(8))  bus_c ();

  seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  seq_multiplier #(.WIDTH(8),  .BITS_PER_CYCLE(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers of width w and multiply, keep 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic s);
    longint unsigned ux, uy, wmask, pmask, p;
    longint          sx, sy;
    wmask = (64'd1 << w) - 64'd1;
    pmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    ux = {32'd0, x} & wmask;
    uy = {32'd0, y} & wmask;
    if (s) begin
      sx = longint'(ux);
      sy = longint'(uy);
      if (ux[w-1]) sx = sx - longint'(64'd1 << w);
      if (uy[w-1]) sy = sy - longint'(64'd1 << w);
      p = longint'(sx * sy);
    end else begin
      p = ux * uy;
    end
    return p & pmask;
  endfunction

  function automatic int iters(input int sel);
    return (sel == 0) ? 32 : (sel == 1) ? 8 : 4;
  endfunction

  task automatic drive(input int sel, input logic st, input logic s,
                       input logic [31:0] x, input logic [31:0] y);
    case (sel)
      0: begin bus_a.start = st; bus_a.signed_mode = s; bus_a.inp1 = x; bus_a.inp2 = y; end
      1: begin bus_b.start = st; bus_b.signed_mode = s; bus_b.inp1 = x; bus_b.inp2 = y; end
      default: begin
        bus_c.start = st; bus_c.signed_mode = s; bus_c.inp1 = x[7:0]; bus_c.inp2 = y[7:0];
      end
    endcase
  endtask

  function automatic logic [3:0] flags(input int sel);
    case (sel)
      0:       return {bus_a.ready, bus_a.busy, bus_a.valid, 1'b0};
      1:       return {bus_b.ready, bus_b.busy, bus_b.valid, 1'b0};
      default: return {bus_c.ready, bus_c.busy, bus_c.valid, 1'b0};
    endcase
  endfunction

  function automatic logic [63:0] get_result(input int sel);
    case (sel)
      0:       return bus_a.result;
      1:       return bus_b.result;
      default: return {56'd0, bus_c.result};
    endcase
  endfunction

  // Issue one multiply, scramble inputs while busy (optionally poking start), wait for valid.
  task automatic run(input int sel, input logic [31:0] x, input logic [31:0] y, input logic s,
                     input int poke_at, output logic [63:0] r, output int lat, output int bcnt);
    logic [3:0] f;
    drive(sel, 1'b1, s, x, y);
    @(posedge clk); #1;
    f = flags(sel);
    check("accept_rdy_busy_valid", {61'd0, f[3:1]}, 64'b010);
    lat  = 1;
    bcnt = 0;
    while (!flags(sel)[1] && lat < 300) begin
      if (flags(sel)[2]) bcnt++;
      drive(sel, (lat == poke_at), $urandom_range(0, 1), $urandom, $urandom);
      @(posedge clk); #1;
      lat++;
    end
    drive(sel, 1'b0, s, x, y);
    if (!flags(sel)[1]) check("valid_timeout", 64'd0, 64'd1);
    r = get_result(sel);
    $display("txn cfg=%0d signed=%0d a=%h b=%h result=%h latency=%0d", sel, s, x, y, r, lat);
  endtask

  task automatic run_check(input int sel, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic [63:0] exp, input string tag);
    logic [63:0] r;
    int lat, bcnt;
    run(sel, x, y, s, -1, r, lat, bcnt);
    check(tag, r, exp);
    check({tag, "_latency"}, 64'(lat), 64'(iters(sel) + 1));
  endtask

  initial begin
    logic [63:0] r, r2;
    int lat, bcnt;
    logic [31:0] x, y;
    logic s;
    logic [7:0] corners [5];

    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_flags", {60'd0, flags(k)}, 64'b1000);
      check("reset_result", get_result(k), 64'd0);
    end

    // 32x1: directed cases
    run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, r, lat, bcnt);
    check("umax_result", r, 64'hFFFF_FFFE_0000_0001);
    check("umax_latency", 64'(lat), 64'd33);
    check("umax_busy_cycles", 64'(bcnt), 64'd32);
    run_check(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
    run_check(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5");
    run_check(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "s_m1xm1");
    run_check(0, 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, "u_m3x5");

    // start during BUSY ignored; start in first DONE cycle accepted
    x = $urandom; y = $urandom;
    run(0, x, y, 1'b1, 5, r, lat, bcnt);
    check("poke_result", r, ref_prod(32, x, y, 1'b1));
    check("poke_latency", 64'(lat), 64'd33);
    x = $urandom; y = $urandom;
    run(0, x, y, 1'b0, -1, r, lat, bcnt);
    check("b2b_result", r, ref_prod(32, x, y, 1'b0));
    check("b2b_latency", 64'(lat), 64'd33);

    // rst in iteration 10
    drive(0, 1'b1, 1'b0, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    check("iter10_busy", {60'd0, flags(0)}, 64'b0100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_flags", {60'd0, flags(0)}, 64'b1000);
    check("midrst_result", get_result(0), 64'd0);
    run_check(0, 32'd7, 32'd6, 1'b0, 64'd42, "after_rst_7x6");

    // rst and start together
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'd9, 32'd9);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd9, 32'd9);
    check("rst_start_flags", {60'd0, flags(0)}, 64'b1000);
    @(posedge clk); #1;
    check("rst_start_idle", {60'd0, flags(0)}, 64'b1000);

    // 32x4: random in both modes, plus hold stability
    for (int i = 0; i < 800; i++) begin
      x = $urandom; y = $urandom; s = i[0];
      if (i % 50 == 3) x = 32'h8000_0000;
      if (i % 50 == 7) y = 32'hFFFF_FFFF;
      run_check(1, x, y, s, ref_prod(32, x, y, s), "b_rand");
      if (i % 100 == 0) begin
        r2 = ref_prod(32, x, y, s);
        repeat (3) @(posedge clk);
        #1;
        check("b_hold_result", get_result(1), r2);
        check("b_hold_valid", {60'd0, flags(1)}, 64'b1010);
      end
    end

    // 8x2: corner grid then random
    run_check(2, 32'h80, 32'h80, 1'b1, 64'h4000, "c_minxmin");
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int m = 0; m < 2; m++) begin
          x = {24'd0, corners[i]}; y = {24'd0, corners[j]}; s = m[0];
          run_check(2, x, y, s, ref_prod(8, x, y, s), "c_corner");
        end
    for (int i = 0; i < 2000; i++) begin
      x = {24'd0, 8'($urandom)}; y = {24'd0, 8'($urandom)}; s = i[0];
      run_check(2, x, y, s, ref_prod(8, x, y, s), "c_rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
